// File: rtl/sync_filter_bus_pkg.sv
// sync_filter_bus_pkg: event-source selectors and width helper shared by the
// input conditioner.
package sync_filter_bus_pkg;
   localparam int EVT_RISE = 0;
   localparam int EVT_FALL = 1;
   localparam int EVT_BOTH = 2;
   function automatic int clog2(input int v);
      int r;
      r = 0;
      while ((1 << r) < v) r++;
      return r < 1 ? 1 : r;
   endfunction
endpackage

// File: rtl/sync_filter_bus_bit.sv
// sync_filter_bit: one channel -- synchronizer chain, stability filter,
// edge pulses and sticky event flag.
module sync_filter_bit
   import sync_filter_bus_pkg::*;
#(
   parameter int   DEPTH    = 2,
   parameter int   FILTER   = 1,
   parameter int   EVT_MODE = EVT_BOTH,
   parameter logic INIT     = 1'b0
) (
   input  logic clock,
   input  logic rst,
   input  logic sig_in,
   input  logic evt_clr,
   output logic sig_out,
   output logic rise,
   output logic fall,
   output logic evt
);
   localparam int CW = clog2(FILTER);
   (* preserve, async_reg = "true" *) logic [DEPTH-1:0] chain;
   logic [CW-1:0] cnt;
   logic s, hit, ev;
   assign s   = chain[0];
   assign hit = (s != sig_out) && (cnt == CW'(FILTER - 1));
   assign ev  = EVT_MODE == EVT_RISE ? rise : EVT_MODE == EVT_FALL ? fall : rise | fall;
   // reset leaves chain and level equal, so no edge can come out of reset itself
   always_ff @(posedge clock)
      if (rst) begin
         chain   <= {DEPTH{INIT}};
         sig_out <= INIT;
         cnt     <= '0;
         rise    <= 1'b0;
         fall    <= 1'b0;
         evt     <= 1'b0;
      end else begin
         chain   <= {sig_in, chain[DEPTH-1:1]};
         sig_out <= hit ? s : sig_out;
         cnt     <= (s == sig_out || hit) ? '0 : cnt + 1'b1;
         rise    <= hit & s;
         fall    <= hit & ~s;
         evt     <= (evt & ~evt_clr) | ev;
      end
endmodule

// File: rtl/sync_filter_bus.sv
// sync_filter_bus: WIDTH independent conditioned channels plus an OR of
// their sticky event flags.
module sync_filter_bus
   import sync_filter_bus_pkg::*;
#(
   parameter int               WIDTH    = 8,
   parameter int               DEPTH    = 2,
   parameter int               FILTER   = 1,
   parameter logic [WIDTH-1:0] INIT     = {WIDTH{1'b0}},
   parameter int               EVT_MODE = EVT_BOTH
) (
   input  logic             clock,
   input  logic             rst,
   input  logic [WIDTH-1:0] sig_in,
   output logic [WIDTH-1:0] sig_out,
   output logic [WIDTH-1:0] rise,
   output logic [WIDTH-1:0] fall,
   output logic [WIDTH-1:0] evt,
   input  logic [WIDTH-1:0] evt_clr,
   output logic             evt_any
);
   if (DEPTH < 2) begin : g_bad_depth
      $error("sync_filter_bus: DEPTH must be >= 2");
   end
   if (FILTER < 1) begin : g_bad_filter
      $error("sync_filter_bus: FILTER must be >= 1");
   end
   if (EVT_MODE < 0 || EVT_MODE > 2) begin : g_bad_mode
      $error("sync_filter_bus: EVT_MODE must be 0..2");
   end
   for (genvar g = 0; g < WIDTH; g++) begin : g_ch
      sync_filter_bit #(
         .DEPTH(DEPTH), .FILTER(FILTER), .EVT_MODE(EVT_MODE), .INIT(INIT[g])
      ) u_bit (
         .clock(clock), .rst(rst), .sig_in(sig_in[g]), .evt_clr(evt_clr[g]),
         .sig_out(sig_out[g]), .rise(rise[g]), .fall(fall[g]), .evt(evt[g])
      );
   end
   assign evt_any = |evt;
endmodule

// File: tb/tb_sync_filter_bus.sv
// tb_sync_filter_bus: three differently parameterised instances driven in
// lockstep and compared every cycle against a window-based reference model.
module tb_sync_filter_bus;
   localparam int NI = 3, N = 8192;
   localparam int DP[NI] = '{2, 3, 2};
   localparam int FL[NI] = '{1, 4, 8};
   localparam int EM[NI] = '{2, 0, 1};
   localparam logic [7:0] IV[NI] = '{8'h00, 8'h00, 8'hFF};
   logic clock = 1'b0, rst = 1'b1;
   logic [7:0] sig_in = 8'h00, evt_clr = 8'h00;
   logic [7:0] so[NI], ro[NI], fo[NI], eo[NI];
   logic ea[NI];
   logic [7:0] m_out[NI], m_rise[NI], m_fall[NI], m_evt[NI];
   logic [7:0] ih[N];
   logic rh[N];
   int lc[NI][8];
   int n = 0, n_chk = 0, n_err = 0, cnt;
   always #5 clock = ~clock;
   for (genvar g = 0; g < NI; g++) begin : g_dut
      sync_filter_bus #(
         .WIDTH(8), .DEPTH(DP[g]), .FILTER(FL[g]), .INIT(IV[g]), .EVT_MODE(EM[g])
      ) dut (
         .clock(clock), .rst(rst), .sig_in(sig_in), .sig_out(so[g]), .rise(ro[g]),
         .fall(fo[g]), .evt(eo[g]), .evt_clr(evt_clr), .evt_any(ea[g])
      );
   end
   task automatic chk(input string tag, input int i, input logic [7:0] obs, input logic [7:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s inst%0d cycle%0d observed=%h expected=%h", tag, i, n, obs, exp);
      end
   endtask
   // synchronized value seen by instance i just before edge e
   function automatic logic s_at(input int i, input int e, input int c);
      if (e - DP[i] < 0) return IV[i][c];
      for (int k = 1; k <= DP[i]; k++)
         if (rh[(e - k) % N]) return IV[i][c];
      return ih[(e - DP[i]) % N][c];
   endfunction
   // sig_out flips once every s sample since the last change/reset, over FILTER edges, differs
   task automatic model();
      logic [7:0] pp;
      logic all;
      ih[n % N] = sig_in;
      rh[n % N] = rst;
      for (int i = 0; i < NI; i++) begin
         pp = EM[i] == 0 ? m_rise[i] : EM[i] == 1 ? m_fall[i] : m_rise[i] | m_fall[i];
         m_rise[i] = 8'h00;
         m_fall[i] = 8'h00;
         if (rst) begin
            m_out[i] = IV[i];
            m_evt[i] = 8'h00;
            for (int c = 0; c < 8; c++) lc[i][c] = n;
         end else begin
            m_evt[i] = (m_evt[i] & ~evt_clr) | pp;
            for (int c = 0; c < 8; c++)
               if (n - FL[i] + 1 > lc[i][c]) begin
                  all = 1'b1;
                  for (int k = 0; k < FL[i]; k++)
                     if (s_at(i, n - k, c) == m_out[i][c]) all = 1'b0;
                  if (all) begin
                     m_out[i][c]  = ~m_out[i][c];
                     m_rise[i][c] = m_out[i][c];
                     m_fall[i][c] = ~m_out[i][c];
                     lc[i][c]     = n;
                  end
               end
         end
      end
      n++;
   endtask
   task automatic check_all();
      for (int i = 0; i < NI; i++) begin
         chk("sig_out", i, so[i], m_out[i]);
         chk("rise", i, ro[i], m_rise[i]);
         chk("fall", i, fo[i], m_fall[i]);
         chk("evt", i, eo[i], m_evt[i]);
         chk("evt_any", i, {7'b0, ea[i]}, {7'b0, |m_evt[i]});
         chk("rise_and_fall", i, ro[i] & fo[i], 8'h00);
      end
   endtask
   task automatic step(input logic r, input logic [7:0] si, input logic [7:0] cl);
      rst = r;
      sig_in = si;
      evt_clr = cl;
      @(posedge clock);
      model();
      #1;
      check_all();
   endtask
   initial begin
      logic [7:0] si;
      step(1, 8'h00, 8'h00);
      step(1, 8'h00, 8'h00);
      chk("reset_out", 0, so[0], 8'h00);
      chk("reset_init", 2, so[2], 8'hFF);
      chk("reset_evt", 0, eo[0], 8'h00);
      chk("reset_any", 0, {7'b0, ea[0]}, 8'h00);
      repeat (6) step(0, 8'h00, 8'h00);
      // sig_in[3] rises before edge k; default instance reacts at k+2
      repeat (3) step(0, 8'h08, 8'h00);
      chk("ch3_level", 0, {7'b0, so[0][3]}, 8'h01);
      chk("ch3_rise", 0, {7'b0, ro[0][3]}, 8'h01);
      step(0, 8'h08, 8'h00);
      chk("ch3_rise_end", 0, {7'b0, ro[0][3]}, 8'h00);
      chk("ch3_evt", 0, {7'b0, eo[0][3]}, 8'h01);
      chk("ch3_any", 0, {7'b0, ea[0]}, 8'h01);
      // 3-cycle glitch is rejected by FILTER=4, a 4-cycle pulse is not
      cnt = 0;
      repeat (3) step(0, 8'h09, 8'h00);
      repeat (10) begin step(0, 8'h08, 8'h00); cnt += int'(ro[1][0]); end
      chk("glitch_level", 1, {7'b0, so[1][0]}, 8'h00);
      chk("glitch_evt", 1, {7'b0, eo[1][0]}, 8'h00);
      chk("glitch_rises", 1, 8'(cnt), 8'h00);
      repeat (4) begin step(0, 8'h09, 8'h00); cnt += int'(ro[1][0]); end
      repeat (10) begin step(0, 8'h08, 8'h00); cnt += int'(ro[1][0]); end
      chk("pulse_rises", 1, 8'(cnt), 8'h01);
      chk("pulse_evt", 1, {7'b0, eo[1][0]}, 8'h01);
      // rise-only events on channel 1, then an explicit clear
      step(0, 8'h08, 8'hFF);
      repeat (8) step(0, 8'h0A, 8'h00);
      repeat (8) step(0, 8'h08, 8'h00);
      chk("rise_only_evt", 1, {7'b0, eo[1][1]}, 8'h01);
      step(0, 8'h08, 8'h02);
      chk("evt_cleared", 1, {7'b0, eo[1][1]}, 8'h00);
      // clear arriving together with a new event keeps the flag
      repeat (3) step(0, 8'h0C, 8'h00);
      step(0, 8'h0C, 8'h04);
      chk("set_beats_clear", 0, {7'b0, eo[0][2]}, 8'h01);
      step(0, 8'h0C, 8'h04);
      chk("late_clear", 0, {7'b0, eo[0][2]}, 8'h00);
      // reset in the middle of a FILTER=8 count
      repeat (7) step(0, 8'h00, 8'h00);
      step(1, 8'h00, 8'h00);
      chk("midcount_init", 2, so[2], 8'hFF);
      chk("midcount_nofall", 2, fo[2], 8'h00);
      repeat (9) step(0, 8'h00, 8'h00);
      chk("fall_not_yet", 2, fo[2], 8'h00);
      step(0, 8'h00, 8'h00);
      chk("fall_all", 2, fo[2], 8'hFF);
      si = 8'h00;
      repeat (3000) begin
         si ^= 8'($urandom & $urandom & $urandom);
         step($urandom_range(0, 199) == 0, si, 8'($urandom & $urandom));
      end
      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end
endmodule
